digital_control: RTL and testbench

DIGITAL_CONTROL -- requirements
Module: digital_control

---
 rtl/digital_control.sv | 145 ++++++++++++++
 tb/tb_digital_control.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/digital_control.sv
// Temperature controller: Moore FSM driving heater / cooler / fan speed,
// plus an independent registered out-of-range alarm. All thresholds are
// signed comparisons against the live (unregistered) temperature input.
module digital_control (
    input  logic       clk,
    input  logic       rstN,     // synchronous reset, active-high
    input  logic [7:0] T,        // two's-complement degrees C
    output logic       Heater,
    output logic       Cooler,
    output logic [3:0] CRS,
    output logic       OUT
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAT  = 3'd1,
        ST_COOL4 = 3'd2,
        ST_COOL6 = 3'd3,
        ST_COOL8 = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        out_r;
    logic        out_next_s;
    logic signed [7:0] temp_s;

    assign temp_s = $signed(T);

    // Next-state logic: one transition per edge, never skipping a state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (temp_s < 8'sd15) begin
                    state_next_s = ST_HEAT;
                end else if (temp_s > 8'sd35) begin
                    state_next_s = ST_COOL4;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HEAT: begin
                // Heating always passes through IDLE before any cooling.
                if (temp_s >= 8'sd30) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HEAT;
                end
            end
            ST_COOL4: begin
                if (temp_s > 8'sd40) begin
                    state_next_s = ST_COOL6;
                end else if (temp_s < 8'sd25) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_COOL4;
                end
            end
            ST_COOL6: begin
                if (temp_s > 8'sd45) begin
                    state_next_s = ST_COOL8;
                end else if (temp_s < 8'sd35) begin
                    state_next_s = ST_COOL4;
                end else begin
                    state_next_s = ST_COOL6;
                end
            end
            ST_COOL8: begin
                if (temp_s < 8'sd40) begin
                    state_next_s = ST_COOL6;
                end else begin
                    state_next_s = ST_COOL8;
                end
            end
            default: begin
                // Unreachable encodings recover to the safe idle state.
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Alarm condition evaluated on the sampled temperature, FSM-independent.
    always_comb begin
        out_next_s = 1'b0;
        if ((temp_s < 8'sd0) || (temp_s > 8'sd50)) begin
            out_next_s = 1'b1;
        end else begin
            out_next_s = 1'b0;
        end
    end

    // State and alarm registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rstN) begin
            state_r <= ST_IDLE;
            out_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            out_r   <= out_next_s;
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        Heater = 1'b0;
        Cooler = 1'b0;
        CRS    = 4'd0;
        case (state_r)
            ST_IDLE: begin
                Heater = 1'b0;
                Cooler = 1'b0;
                CRS    = 4'd0;
            end
            ST_HEAT: begin
                Heater = 1'b1;
                Cooler = 1'b0;
                CRS    = 4'd0;
            end
            ST_COOL4: begin
                Heater = 1'b0;
                Cooler = 1'b1;
                CRS    = 4'd4;
            end
            ST_COOL6: begin
                Heater = 1'b0;
                Cooler = 1'b1;
                CRS    = 4'd6;
            end
            ST_COOL8: begin
                Heater = 1'b0;
                Cooler = 1'b1;
                CRS    = 4'd8;
            end
            default: begin
                Heater = 1'b0;
                Cooler = 1'b0;
                CRS    = 4'd0;
            end
        endcase
    end

    assign OUT = out_r;

endmodule

// File: tb/tb_digital_control.sv
// Self-checking bench for digital_control: a behavioural model (heating flag
// plus fan speed) checked every cycle, with directed scenarios and literal
// expectations at the thresholds.
module tb_digital_control;

    logic       clk;
    logic       rstN;
    logic [7:0] T;
    logic       Heater;
    logic       Cooler;
    logic [3:0] CRS;
    logic       OUT;

    int errors = 0;
    int checks = 0;

    // Model state: whether heating, fan speed (0 = not cooling), alarm.
    int m_heat = 0;
    int m_spd  = 0;
    int m_out  = 0;
    bit valid  = 1'b0;

    digital_control dut (
        .clk   (clk),
        .rstN  (rstN),
        .T     (T),
        .Heater(Heater),
        .Cooler(Cooler),
        .CRS   (CRS),
        .OUT   (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model advanced on each rising edge.
    always @(posedge clk) begin
        int ts;
        int nh;
        int ns;
        ts = int'($signed(T));
        nh = m_heat;
        ns = m_spd;
        if (rstN === 1'b1) begin
            m_heat <= 0;
            m_spd  <= 0;
            m_out  <= 0;
            valid  <= 1'b1;
        end else begin
            if (nh == 1) begin
                if (ts >= 30) nh = 0;
            end else if (ns == 0) begin
                if (ts < 15) nh = 1;
                else if (ts > 35) ns = 4;
            end else if (ns == 4) begin
                if (ts > 40) ns = 6;
                else if (ts < 25) ns = 0;
            end else if (ns == 6) begin
                if (ts > 45) ns = 8;
                else if (ts < 35) ns = 4;
            end else begin
                if (ts < 40) ns = 6;
            end
            m_heat <= nh;
            m_spd  <= ns;
            m_out  <= ((ts < 0) || (ts > 50)) ? 1 : 0;
        end
    end

    // Every-cycle comparison against the model plus output invariants.
    always @(negedge clk) begin
        if (valid) begin
            checks = checks + 1;
            if ((int'(Heater) != m_heat) || (int'(Cooler) != ((m_spd != 0) ? 1 : 0)) ||
                (int'(CRS) != m_spd) || (int'(OUT) != m_out)) begin
                errors = errors + 1;
                $display("FAIL model t=%0t: got H=%0d C=%0d CRS=%0d OUT=%0d, expected H=%0d C=%0d CRS=%0d OUT=%0d",
                         $time, Heater, Cooler, CRS, OUT, m_heat, (m_spd != 0), m_spd, m_out);
            end
            checks = checks + 1;
            if ((Heater && Cooler) || !(CRS == 4'd0 || CRS == 4'd4 || CRS == 4'd6 || CRS == 4'd8) ||
                ((CRS != 4'd0) != Cooler)) begin
                errors = errors + 1;
                $display("FAIL invariant t=%0t: got H=%0d C=%0d CRS=%0d, required exclusive H/C and CRS in {0,4,6,8} iff C",
                         $time, Heater, Cooler, CRS);
            end
        end
    end

    // Apply one input vector and let one rising edge sample it.
    task automatic tick(input int t, input logic r);
        T    = 8'(t);
        rstN = r;
        @(posedge clk);
        #1;
    endtask

    // Compare outputs against hand-computed literals.
    task automatic expect_out(input string name, input logic h, input logic c,
                              input logic [3:0] s, input logic o);
        checks = checks + 1;
        if (Heater !== h || Cooler !== c || CRS !== s || OUT !== o) begin
            errors = errors + 1;
            $display("FAIL %s: got H=%0d C=%0d CRS=%0d OUT=%0d, expected H=%0d C=%0d CRS=%0d OUT=%0d",
                     name, Heater, Cooler, CRS, OUT, h, c, s, o);
        end
    endtask

    initial begin
        T    = 8'd20;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        tick(20, 1'b1);
        expect_out("reset", 1'b0, 1'b0, 4'd0, 1'b0);

        // Rising ramp from IDLE
        for (int t = -10; t <= 60; t++) begin
            tick(t, 1'b0);
            if (t == -10) expect_out("rise_-10", 1'b1, 1'b0, 4'd0, 1'b1);
            if (t == -1)  expect_out("rise_-1",  1'b1, 1'b0, 4'd0, 1'b1);
            if (t == 0)   expect_out("rise_0",   1'b1, 1'b0, 4'd0, 1'b0);
            if (t == 29)  expect_out("rise_29",  1'b1, 1'b0, 4'd0, 1'b0);
            if (t == 30)  expect_out("rise_30",  1'b0, 1'b0, 4'd0, 1'b0);
            if (t == 35)  expect_out("rise_35",  1'b0, 1'b0, 4'd0, 1'b0);
            if (t == 36)  expect_out("rise_36",  1'b0, 1'b1, 4'd4, 1'b0);
            if (t == 40)  expect_out("rise_40",  1'b0, 1'b1, 4'd4, 1'b0);
            if (t == 41)  expect_out("rise_41",  1'b0, 1'b1, 4'd6, 1'b0);
            if (t == 45)  expect_out("rise_45",  1'b0, 1'b1, 4'd6, 1'b0);
            if (t == 46)  expect_out("rise_46",  1'b0, 1'b1, 4'd8, 1'b0);
            if (t == 50)  expect_out("rise_50",  1'b0, 1'b1, 4'd8, 1'b0);
            if (t == 51)  expect_out("rise_51",  1'b0, 1'b1, 4'd8, 1'b1);
        end

        // Falling ramp from COOL8
        for (int t = 60; t >= -10; t--) begin
            tick(t, 1'b0);
            if (t == 40) expect_out("fall_40", 1'b0, 1'b1, 4'd8, 1'b0);
            if (t == 39) expect_out("fall_39", 1'b0, 1'b1, 4'd6, 1'b0);
            if (t == 35) expect_out("fall_35", 1'b0, 1'b1, 4'd6, 1'b0);
            if (t == 34) expect_out("fall_34", 1'b0, 1'b1, 4'd4, 1'b0);
            if (t == 25) expect_out("fall_25", 1'b0, 1'b1, 4'd4, 1'b0);
            if (t == 24) expect_out("fall_24", 1'b0, 1'b0, 4'd0, 1'b0);
            if (t == 15) expect_out("fall_15", 1'b0, 1'b0, 4'd0, 1'b0);
            if (t == 14) expect_out("fall_14", 1'b1, 1'b0, 4'd0, 1'b0);
        end

        // Reset mid-cooling
        tick(20, 1'b1);
        for (int i = 0; i < 5; i++) tick(47, 1'b0);
        expect_out("hold47_cool8", 1'b0, 1'b1, 4'd8, 1'b0);
        tick(47, 1'b1);
        expect_out("reset_mid_cool", 1'b0, 1'b0, 4'd0, 1'b0);

        // Hysteresis hold in HEAT, then reset mid-heating
        tick(10, 1'b0);
        expect_out("enter_heat", 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) tick(20, 1'b0);
        expect_out("hold20_heat", 1'b1, 1'b0, 4'd0, 1'b0);
        tick(-5, 1'b1);
        expect_out("reset_mid_heat", 1'b0, 1'b0, 4'd0, 1'b0);

        // Hysteresis hold in COOL4
        tick(37, 1'b0);
        expect_out("enter_cool4", 1'b0, 1'b1, 4'd4, 1'b0);
        for (int i = 0; i < 10; i++) tick(30, 1'b0);
        expect_out("hold30_cool4", 1'b0, 1'b1, 4'd4, 1'b0);

        // Step jump from HEAT to 60
        tick(20, 1'b1);
        tick(10, 1'b0);
        expect_out("step_heat", 1'b1, 1'b0, 4'd0, 1'b0);
        tick(60, 1'b0);
        expect_out("step_e1", 1'b0, 1'b0, 4'd0, 1'b1);
        tick(60, 1'b0);
        expect_out("step_e2", 1'b0, 1'b1, 4'd4, 1'b1);
        tick(60, 1'b0);
        expect_out("step_e3", 1'b0, 1'b1, 4'd6, 1'b1);
        tick(60, 1'b0);
        expect_out("step_e4", 1'b0, 1'b1, 4'd8, 1'b1);

        // Signed extreme values
        tick(-128, 1'b0);
        expect_out("min_temp", 1'b0, 1'b1, 4'd6, 1'b1);
        tick(127, 1'b0);
        expect_out("max_temp", 1'b0, 1'b1, 4'd8, 1'b1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
